sha_block_sequencer: RTL and testbench

//  Parametrised successor to the single-block word sequencer. Accepts whole message blocks over a

---
 rtl/sha_seq_pkg.sv | 28 ++
 rtl/sha_seq_word_sel.sv | 55 +++++
 rtl/sha_block_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sha_block_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_seq_pkg.sv
// Shared types and constants for the SHA-1 block sequencer: FSM state encoding,
// default parameter values and the word-order index helper.
`timescale 1ns/1ps
package sha_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_N_WORDS     = 16;
  localparam int DEF_MSW_FIRST   = 1;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 1023;

  // Maps the k-th transmitted word onto its position inside the captured block.
  function automatic int idx(input int cnt, input bit msw_first, input int n_words);
    if (msw_first) begin
      return n_words - 1 - cnt;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/sha_seq_word_sel.sv
// Block capture register, word counter and registered word mux feeding the core.
`timescale 1ns/1ps
module sha_seq_word_sel
  import sha_seq_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int N_WORDS   = DEF_N_WORDS,
  parameter int MSW_FIRST = DEF_MSW_FIRST
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cap_i,
  input  logic                      load_i,
  input  logic [N_WORDS*WORD_W-1:0] blk_data_i,
  output logic [WORD_W-1:0]         word_o,
  output logic                      tc_o
);

  localparam int CW = $clog2(N_WORDS);

  logic [N_WORDS*WORD_W-1:0] cap_r;
  logic [CW-1:0]             cnt_r;
  logic [CW-1:0]             cnt_inc_s;
  logic [CW-1:0]             first_idx_s;
  logic [CW-1:0]             nxt_idx_s;
  logic [WORD_W-1:0]         word_r;

  assign cnt_inc_s   = cnt_r + CW'(1);
  assign tc_o        = (cnt_r == CW'(N_WORDS - 1));
  assign first_idx_s = CW'(idx(0, MSW_FIRST != 0, N_WORDS));
  assign nxt_idx_s   = CW'(idx(int'(cnt_inc_s), MSW_FIRST != 0, N_WORDS));
  assign word_o      = word_r;

  // The word for the next LOAD cycle is prepared one cycle ahead so the core sees a registered bus.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cap_r  <= '0;
      cnt_r  <= '0;
      word_r <= '0;
    end else if (cap_i) begin
      cap_r  <= blk_data_i;
      cnt_r  <= '0;
      word_r <= blk_data_i[first_idx_s*WORD_W +: WORD_W];
    end else if (load_i) begin
      cap_r  <= cap_r;
      cnt_r  <= cnt_inc_s;
      word_r <= tc_o ? '0 : cap_r[nxt_idx_s*WORD_W +: WORD_W];
    end else begin
      cap_r  <= cap_r;
      cnt_r  <= '0;
      word_r <= '0;
    end
  end

endmodule

// File: rtl/sha_block_sequencer.sv
// Buffers one message block and streams it word by word into the SHA-1 core.
// Optional WAIT timeout enabled by defining SHA_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module sha_block_sequencer
  import sha_seq_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int N_WORDS     = DEF_N_WORDS,
  parameter int MSW_FIRST   = DEF_MSW_FIRST,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_WORDS*WORD_W-1:0] blk_data_i,
  input  logic                      blk_valid_i,
  input  logic                      blk_last_i,
  output logic                      blk_ready_o,
  output logic [WORD_W-1:0]         core_data_o,
  output logic                      core_load_o,
  output logic                      core_start_o,
  output logic                      core_first_o,
  input  logic                      core_valid_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_W-1:0]          blk_cnt_o,
  output logic                      timeout_o
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic             accept_s;
  logic             wait_done_s;
  logic             tmo_hit_s;
  logic             tc_s;
  logic             first_r;
  logic             last_r;
  logic [CNT_W-1:0] blk_cnt_r;
  logic             ready_r;
  logic             load_r;
  logic             start_r;
  logic             first_out_r;
  logic             busy_r;
  logic             done_r;
  logic             tmo_r;

  assign accept_s    = (state_r == ST_IDLE) && blk_valid_i;
  assign wait_done_s = (state_r == ST_WAIT) && core_valid_i;

  sha_seq_word_sel #(
    .WORD_W    (WORD_W),
    .N_WORDS   (N_WORDS),
    .MSW_FIRST (MSW_FIRST)
  ) u_word_sel (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cap_i      (accept_s),
    .load_i     (state_r == ST_LOAD),
    .blk_data_i (blk_data_i),
    .word_o     (core_data_o),
    .tc_o       (tc_s)
  );

`ifdef SHA_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt_r;

  // A valid result in the final allowed cycle still wins over the timeout.
  assign tmo_hit_s = (state_r == ST_WAIT) && !core_valid_i && (wait_cnt_r == TW'(TIMEOUT_CYC - 1));

  // WAIT cycle counter, held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_r <= '0;
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + TW'(1);
    end
  end
`else
  localparam int tmo_cyc_unused_c = TIMEOUT_CYC;
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (blk_valid_i) state_nxt_s = ST_LOAD;
        else             state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (tc_s) state_nxt_s = ST_START;
        else      state_nxt_s = ST_LOAD;
      end
      ST_START: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_done_s)    state_nxt_s = ST_IDLE;
        else if (tmo_hit_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and Moore outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      load_r      <= 1'b0;
      start_r     <= 1'b0;
      first_out_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      tmo_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ready_r     <= (state_nxt_s == ST_IDLE);
      load_r      <= (state_nxt_s == ST_LOAD);
      start_r     <= (state_nxt_s == ST_START);
      first_out_r <= ((state_nxt_s == ST_LOAD) || (state_nxt_s == ST_START)) && first_r;
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= wait_done_s && last_r;
      tmo_r       <= tmo_hit_s;
    end
  end

  // Message tracking: first-block flag, captured last flag and completed-block counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      first_r   <= 1'b1;
      last_r    <= 1'b0;
      blk_cnt_r <= '0;
    end else if (accept_s) begin
      first_r   <= first_r;
      last_r    <= blk_last_i;
      blk_cnt_r <= first_r ? '0 : blk_cnt_r;
    end else if (wait_done_s) begin
      first_r   <= last_r;
      last_r    <= last_r;
      blk_cnt_r <= (blk_cnt_r == {CNT_W{1'b1}}) ? blk_cnt_r : blk_cnt_r + CNT_W'(1);
    end else if (tmo_hit_s) begin
      first_r   <= 1'b1;
      last_r    <= last_r;
      blk_cnt_r <= '0;
    end else begin
      first_r   <= first_r;
      last_r    <= last_r;
      blk_cnt_r <= blk_cnt_r;
    end
  end

  assign blk_ready_o  = ready_r;
  assign core_load_o  = load_r;
  assign core_start_o = start_r;
  assign core_first_o = first_out_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign blk_cnt_o    = blk_cnt_r;
  assign timeout_o    = tmo_r;

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Self-checking bench for sha_block_sequencer: default-geometry instance plus an
// LSW-first 4x8 instance; timeout behaviour follows SHA_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_sha_block_sequencer;

`ifdef SHA_SEQ_TIMEOUT_EN
  localparam int WAIT_MAX = 6;
`else
  localparam int WAIT_MAX = 20;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [511:0] blk_data_i;
  logic         blk_valid_i;
  logic         blk_last_i;
  logic         blk_ready_o;
  logic [31:0]  core_data_o;
  logic         core_load_o;
  logic         core_start_o;
  logic         core_first_o;
  logic         core_valid_i;
  logic         busy_o;
  logic         done_o;
  logic [15:0]  blk_cnt_o;
  logic         timeout_o;

  logic [31:0]  d2_blk;
  logic         d2_valid, d2_last, d2_ready, d2_load, d2_start, d2_first;
  logic         d2_core_valid, d2_busy, d2_done, d2_tmo;
  logic [7:0]   d2_data;
  logic [15:0]  d2_cnt;

  int checks = 0;
  int errors = 0;
  bit first_exp = 1'b1;
  int cnt_exp   = 0;

  always #5 clk_i = ~clk_i;

  sha_block_sequencer #(
    .WORD_W(32), .N_WORDS(16), .MSW_FIRST(1), .CNT_W(16), .TIMEOUT_CYC(8)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .blk_data_i(blk_data_i), .blk_valid_i(blk_valid_i),
    .blk_last_i(blk_last_i), .blk_ready_o(blk_ready_o), .core_data_o(core_data_o),
    .core_load_o(core_load_o), .core_start_o(core_start_o), .core_first_o(core_first_o),
    .core_valid_i(core_valid_i), .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o),
    .timeout_o(timeout_o)
  );

  sha_block_sequencer #(
    .WORD_W(8), .N_WORDS(4), .MSW_FIRST(0), .CNT_W(16), .TIMEOUT_CYC(8)
  ) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .blk_data_i(d2_blk), .blk_valid_i(d2_valid),
    .blk_last_i(d2_last), .blk_ready_o(d2_ready), .core_data_o(d2_data),
    .core_load_o(d2_load), .core_start_o(d2_start), .core_first_o(d2_first),
    .core_valid_i(d2_core_valid), .busy_o(d2_busy), .done_o(d2_done), .blk_cnt_o(d2_cnt),
    .timeout_o(d2_tmo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Offer a block in IDLE, then follow it through all LOAD cycles and the START cycle.
  task automatic send_load(input logic [511:0] blk, input bit last, input bit keep_valid, input bit early);
    logic [511:0] sh;
    blk_data_i  = blk;
    blk_last_i  = last;
    blk_valid_i = 1'b1;
    check("ready_idle", blk_ready_o, 1);
    @(negedge clk_i);
    blk_data_i  = {16{$urandom()}};
    blk_last_i  = 1'($urandom_range(0, 1));
    blk_valid_i = keep_valid;
    for (int k = 0; k < 16; k++) begin
      sh = blk >> (32 * (15 - k));
      check("load", core_load_o, 1);
      check("data", core_data_o, sh[31:0]);
      check("first_load", core_first_o, first_exp);
      check("ready_busy", blk_ready_o, 0);
      check("start_in_load", core_start_o, 0);
      core_valid_i = early && (k == 3);
      @(negedge clk_i);
    end
    core_valid_i = early;
    check("start", core_start_o, 1);
    check("load_end", core_load_o, 0);
    check("first_start", core_first_o, first_exp);
    @(negedge clk_i);
    core_valid_i = 1'b0;
  endtask

  // Hold WAIT for wait_cyc cycles, return the core result, then check the IDLE entry.
  task automatic finish_wait(input int wait_cyc, input bit last);
    for (int i = 0; i < wait_cyc; i++) begin
      check("busy_wait", busy_o, 1);
      check("done_wait", done_o, 0);
      check("first_wait", core_first_o, 0);
      @(negedge clk_i);
    end
    core_valid_i = 1'b1;
    @(negedge clk_i);
    core_valid_i = 1'b0;
    cnt_exp   = first_exp ? 1 : ((cnt_exp == 65535) ? cnt_exp : cnt_exp + 1);
    first_exp = last;
    check("done", done_o, last);
    check("blk_cnt", blk_cnt_o, cnt_exp);
    check("busy_idle", busy_o, 0);
    check("ready_after", blk_ready_o, 1);
    check("timeout_none", timeout_o, 0);
  endtask

  initial begin
    logic [511:0] blk;
    int           len;
    rst_i = 1'b0; blk_data_i = '0; blk_valid_i = 1'b0; blk_last_i = 1'b0; core_valid_i = 1'b0;
    d2_blk = '0; d2_valid = 1'b0; d2_last = 1'b0; d2_core_valid = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", blk_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_load", core_load_o, 0);
    check("rst_start", core_start_o, 0);
    check("rst_first", core_first_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", blk_cnt_o, 0);
    check("rst_data", core_data_o, 0);
    check("rst_tmo", timeout_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Single block with words 0..15, sent MSW first.
    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'(i);
    send_load(blk, 1'b1, 1'b0, 1'b0);
    finish_wait(WAIT_MAX, 1'b1);

    // Three-block message with blk_valid_i held high across busy periods.
    for (int b = 0; b < 3; b++) begin
      send_load(rand_blk(), b == 2, b != 2, 1'b0);
      finish_wait($urandom_range(0, WAIT_MAX), b == 2);
    end

    // Random messages.
    for (int m = 0; m < 4; m++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        send_load(rand_blk(), b == len - 1, (b != len - 1) && ($urandom_range(0, 1) == 1), 1'b0);
        finish_wait($urandom_range(0, WAIT_MAX), b == len - 1);
      end
    end

    // core_valid_i pulses during LOAD and START must be ignored.
    send_load(rand_blk(), 1'b1, 1'b0, 1'b1);
    finish_wait(3, 1'b1);

    // Reset in the middle of LOAD.
    blk_data_i = rand_blk(); blk_last_i = 1'b0; blk_valid_i = 1'b1;
    @(negedge clk_i);
    blk_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", blk_ready_o, 1);
    check("mid_rst_load", core_load_o, 0);
    check("mid_rst_data", core_data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    first_exp = 1'b1;
    cnt_exp   = 0;
    @(negedge clk_i);
    send_load(rand_blk(), 1'b0, 1'b0, 1'b0);
    finish_wait(2, 1'b0);

    // Second block of the message never gets a result.
    send_load(rand_blk(), 1'b0, 1'b0, 1'b0);
`ifdef SHA_SEQ_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      check("tmo_wait_busy", busy_o, 1);
      check("tmo_early", timeout_o, 0);
      @(negedge clk_i);
    end
    check("tmo_pulse", timeout_o, 1);
    check("tmo_idle", busy_o, 0);
    check("tmo_cnt", blk_cnt_o, 0);
    check("tmo_done", done_o, 0);
    first_exp = 1'b1;
    cnt_exp   = 0;
    @(negedge clk_i);
    check("tmo_one_cycle", timeout_o, 0);
`else
    for (int i = 0; i < 30; i++) begin
      check("no_tmo_busy", busy_o, 1);
      check("no_tmo_pulse", timeout_o, 0);
      @(negedge clk_i);
    end
    finish_wait(0, 1'b0);
`endif
    send_load(rand_blk(), 1'b1, 1'b0, 1'b0);
    finish_wait(1, 1'b1);

    // LSW-first 4x8 instance.
    d2_blk = 32'h4433_2211; d2_last = 1'b1; d2_valid = 1'b1;
    check("d2_ready", d2_ready, 1);
    @(negedge clk_i);
    d2_valid = 1'b0;
    d2_blk   = 32'hdead_beef;
    for (int k = 0; k < 4; k++) begin
      check("d2_load", d2_load, 1);
      check("d2_data", d2_data, (32'h4433_2211 >> (8 * k)) & 32'hff);
      check("d2_first", d2_first, 1);
      @(negedge clk_i);
    end
    check("d2_start", d2_start, 1);
    @(negedge clk_i);
    d2_core_valid = 1'b1;
    @(negedge clk_i);
    d2_core_valid = 1'b0;
    check("d2_done", d2_done, 1);
    check("d2_cnt", d2_cnt, 1);
    check("d2_busy", d2_busy, 0);
    check("d2_tmo", d2_tmo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
